// File: rtl/mux_logical_tb_pkg.sv
// Shared types and constants for the mux_logical response monitor.
package mux_logical_tb_pkg;

  localparam int          MISR_W    = 16;
  // Feedback taps 15,14,12,3 as a mask over the signature register.
  localparam logic [15:0] MISR_POLY = 16'hD008;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // One MISR shift: feedback into bit 0, then xor the zero-extended sample.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s,
                                                  input logic [MISR_W-1:0] d);
    return {s[MISR_W-2:0], ^(s & MISR_POLY)} ^ d;
  endfunction

endpackage

// File: rtl/resp_misr16.sv
// 16-bit MISR signature register. clr reloads the seed, en compacts din.
module resp_misr16
  import mux_logical_tb_pkg::*;
#(
  parameter int          DIN_W = 3,
  parameter logic [15:0] SEED  = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DIN_W-1:0]  din,
  output logic [MISR_W-1:0] sig
);

  // Signature update: reset/clear to seed, otherwise step on each sample.
  always_ff @(posedge clk) begin
    if (!rst_n)   sig <= SEED;
    else if (clr) sig <= SEED;
    else if (en)  sig <= misr_step(sig, MISR_W'(din));
  end

endmodule

// File: rtl/mux_logical_resp_mon.sv
// Response monitor for the exhaustive mux_logical flow: accepts one vector
// per handshake, waits SETTLE_CYC cycles, samples dut_out, counts mismatches
// and compacts samples into a MISR. Optional macro RESP_MON_TRACE_EN adds
// first-fail capture ports and a vector order check.
module mux_logical_resp_mon
  import mux_logical_tb_pkg::*;
#(
  parameter int          N_IN       = 6,
  parameter int          W_OUT      = 3,
  parameter int          SETTLE_CYC = 4,
  parameter logic [15:0] MISR_SEED  = 16'hFFFF,
  parameter logic [15:0] EXP_SIG    = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [N_IN-1:0]   vec_idx,
  input  logic [W_OUT-1:0]  exp_out,
  input  logic [W_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt,
  output logic [MISR_W-1:0] sig
`ifdef RESP_MON_TRACE_EN
  ,
  output logic              ff_valid,
  output logic [N_IN-1:0]   ff_idx,
  output logic [W_OUT-1:0]  ff_got,
  output logic [W_OUT-1:0]  ff_exp
`endif
);

  localparam int            CW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [N_IN:0] VEC_LAST = (N_IN+1)'(2**N_IN - 1);

  typedef struct packed {
    logic [N_IN-1:0]  idx;
    logic [W_OUT-1:0] exp;
  } vec_req_t;

  state_e          state;
  vec_req_t        req_q;
  logic [N_IN:0]   vec_cnt;
  logic [CW-1:0]   settle_cnt;
  logic            run_start;
  logic            mismatch;

  // start only matters when no run is in flight.
  assign run_start = start && (state == ST_IDLE || state == ST_DONE);

  assign vec_ready = (state == ST_ACCEPT);
  assign busy      = (state == ST_ACCEPT) || (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done      = (state == ST_DONE);
  assign pass      = done && (err_cnt == '0) && (sig == EXP_SIG);

  // Sample compare; X/Z on dut_out is treated as a mismatch.
  always_comb begin
    mismatch = (dut_out !== req_q.exp);
`ifdef RESP_MON_TRACE_EN
    if (req_q.idx != vec_cnt[N_IN-1:0]) mismatch = 1'b1;
`endif
  end

`ifndef RESP_MON_TRACE_EN
  // Index is only consumed by the order check.
  logic unused_idx;
  assign unused_idx = ^req_q.idx;
`endif

  // Run FSM with vector/settle counters and saturating error count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      vec_cnt    <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_ACCEPT;
            vec_cnt    <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
          end
        end
        ST_ACCEPT: begin
          if (vec_valid) begin
            req_q      <= '{idx: vec_idx, exp: exp_out};
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SET_LAST) begin
            settle_cnt <= '0;
            state      <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
          vec_cnt <= vec_cnt + 1'b1;
          state   <= (vec_cnt == VEC_LAST) ? ST_DONE : ST_ACCEPT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RESP_MON_TRACE_EN
  // First-fail capture: load on the first mismatch of a run, then freeze.
  always_ff @(posedge clk) begin
    if (!rst_n || run_start) begin
      ff_valid <= 1'b0;
      ff_idx   <= '0;
      ff_got   <= '0;
      ff_exp   <= '0;
    end else if (state == ST_SAMPLE && mismatch && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_idx   <= req_q.idx;
      ff_got   <= dut_out;
      ff_exp   <= req_q.exp;
    end
  end
`endif

  resp_misr16 #(.DIN_W(W_OUT), .SEED(MISR_SEED)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_start),
    .en    (state == ST_SAMPLE),
    .din   (dut_out),
    .sig   (sig)
  );

endmodule
